// File: rtl/mem_access_pkg.sv
// Shared state encoding and size codes for the load/store sequencer.
package mem_access_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_RD_WAIT   = 3'd2,
        S_MDR_LATCH = 3'd3,
        S_LOAD_WB   = 3'd4,
        S_STORE_WR  = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    function automatic logic bad_access(
        input logic [1:0] sz,
        input logic [1:0] lo,
        input logic       chk
    );
        return (sz == SZ_ILL)
            || (chk && sz == SZ_HALF && lo[0])
            || (chk && sz == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Read-latency wait counter; tc marks the last wait cycle.
module wait_counter
    import mem_access_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W   = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam int TCI = (MEM_LATENCY < 1) ? 0 : MEM_LATENCY - 1;
    localparam logic [W-1:0] TCV = W'(TCI);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == TCV);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: memory wait states, sub-word RMW stores, alignment check.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CHECK_ALIGN = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              align_err,
    output logic              mem_addr_sel,
    output logic              memrw,
    output logic              mdrwrite,
    output logic              regwrite,
    output logic [1:0]        lscontrol,
    output logic [1:0]        sscontrol,
    output logic [1:0]        addr_lo
);
    state_t state;
    logic   st_r;
    logic   tc;
    logic   in_wait;
    logic   unused_addr;

    // Upper address bits travel on the ALUOut path, not through this block.
    assign unused_addr = ^addr[ADDR_W-1:2];
    assign in_wait     = (state == S_RD_WAIT);

    wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (in_wait && tc),
        .en    (in_wait),
        .tc    (tc)
    );

    // Outputs are set for the state being entered, so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            st_r         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            align_err    <= 1'b0;
            mem_addr_sel <= 1'b0;
            memrw        <= 1'b0;
            mdrwrite     <= 1'b0;
            regwrite     <= 1'b0;
            lscontrol    <= 2'b00;
            sscontrol    <= 2'b00;
            addr_lo      <= 2'b00;
        end else begin
            done         <= 1'b0;
            align_err    <= 1'b0;
            mem_addr_sel <= 1'b0;
            memrw        <= 1'b0;
            mdrwrite     <= 1'b0;
            regwrite     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        st_r      <= is_store;
                        lscontrol <= size;
                        sscontrol <= size;
                        addr_lo   <= addr[1:0];
                        busy      <= 1'b1;
                        if (bad_access(size, addr[1:0], CHECK_ALIGN != 0)) begin
                            state     <= S_ERR;
                            align_err <= 1'b1;
                        end else begin
                            state        <= S_ADDR;
                            mem_addr_sel <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    mem_addr_sel <= 1'b1;
                    if (st_r && lscontrol == SZ_WORD) begin
                        state <= S_STORE_WR;
                        memrw <= 1'b1;
                        done  <= 1'b1;
                    end else if (MEM_LATENCY == 0) begin
                        state    <= S_MDR_LATCH;
                        mdrwrite <= 1'b1;
                    end else begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    mem_addr_sel <= 1'b1;
                    if (tc) begin
                        state    <= S_MDR_LATCH;
                        mdrwrite <= 1'b1;
                    end
                end
                S_MDR_LATCH: begin
                    done <= 1'b1;
                    if (st_r) begin
                        state        <= S_STORE_WR;
                        mem_addr_sel <= 1'b1;
                        memrw        <= 1'b1;
                    end else begin
                        state    <= S_LOAD_WB;
                        regwrite <= 1'b1;
                    end
                end
                S_LOAD_WB, S_STORE_WR, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three parameterisations driven in parallel.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic [31:0] addr;

    logic       busy [3];
    logic       done [3];
    logic       aerr [3];
    logic       sel  [3];
    logic       mrw  [3];
    logic       mdr  [3];
    logic       rw   [3];
    logic [1:0] lsc  [3];
    logic [1:0] ssc  [3];
    logic [1:0] alo  [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LATENCY(1), .CHECK_ALIGN(1), .ADDR_W(32)) u_a (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .size(size), .addr(addr), .busy(busy[0]), .done(done[0]),
        .align_err(aerr[0]), .mem_addr_sel(sel[0]), .memrw(mrw[0]),
        .mdrwrite(mdr[0]), .regwrite(rw[0]), .lscontrol(lsc[0]),
        .sscontrol(ssc[0]), .addr_lo(alo[0])
    );

    mem_access_ctrl #(.MEM_LATENCY(3), .CHECK_ALIGN(0), .ADDR_W(32)) u_b (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .size(size), .addr(addr), .busy(busy[1]), .done(done[1]),
        .align_err(aerr[1]), .mem_addr_sel(sel[1]), .memrw(mrw[1]),
        .mdrwrite(mdr[1]), .regwrite(rw[1]), .lscontrol(lsc[1]),
        .sscontrol(ssc[1]), .addr_lo(alo[1])
    );

    mem_access_ctrl #(.MEM_LATENCY(0), .CHECK_ALIGN(1), .ADDR_W(32)) u_c (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .size(size), .addr(addr), .busy(busy[2]), .done(done[2]),
        .align_err(aerr[2]), .mem_addr_sel(sel[2]), .memrw(mrw[2]),
        .mdrwrite(mdr[2]), .regwrite(rw[2]), .lscontrol(lsc[2]),
        .sscontrol(ssc[2]), .addr_lo(alo[2])
    );

    function automatic int ml_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 0;
    endfunction

    function automatic int ca_of(int i);
        return (i == 1) ? 0 : 1;
    endfunction

    // {busy,done,align_err,mem_addr_sel,memrw,mdrwrite,regwrite,ls,ss,lo}
    function automatic logic [12:0] obs(int i);
        return {busy[i], done[i], aerr[i], sel[i], mrw[i], mdr[i], rw[i],
                lsc[i], ssc[i], alo[i]};
    endfunction

    function automatic logic is_err(int ca, logic [1:0] sz, logic [1:0] lo);
        if (sz == 2'd3) return 1'b1;
        if (ca == 0) return 1'b0;
        if (sz == 2'd1) return lo[0];
        if (sz == 2'd2) return lo != 2'd0;
        return 1'b0;
    endfunction

    // Cycles from accept to the final cycle, inclusive.
    function automatic int acc_len(int ml, int ca, logic st,
                                   logic [1:0] sz, logic [1:0] lo);
        if (is_err(ca, sz, lo)) return 1;
        if (st && sz == 2'd2) return 2;
        return 3 + ml;
    endfunction

    // Expected outputs k cycles after the accepting edge (k > n is idle).
    function automatic logic [12:0] exp_vec(int ml, int ca, logic st,
                                            logic [1:0] sz, logic [1:0] lo,
                                            int k);
        int   n;
        logic e, act, fin;
        logic b, d, a, s, m, md, r;
        e   = is_err(ca, sz, lo);
        n   = acc_len(ml, ca, st, sz, lo);
        act = (k >= 1) && (k <= n);
        fin = (k == n);
        b   = act;
        d   = fin && !e;
        a   = e && (k == 1);
        s   = act && !e && !(fin && !st);
        m   = fin && !e && st;
        md  = !e && (n != 2) && (k == n - 1);
        r   = fin && !e && !st;
        return {b, d, a, s, m, md, r, sz, sz, lo};
    endfunction

    task automatic test_single_access(logic st, logic [1:0] sz, logic [31:0] ad);
        int          nmax;
        logic [12:0] e;
        nmax = 0;
        for (int i = 0; i < 3; i++)
            if (acc_len(ml_of(i), ca_of(i), st, sz, ad[1:0]) > nmax)
                nmax = acc_len(ml_of(i), ca_of(i), st, sz, ad[1:0]);
        @(negedge clk);
        start = 1'b1; is_store = st; size = sz; addr = ad;
        for (int k = 1; k <= nmax + 1; k++) begin
            @(negedge clk);
            start    = 1'b0;
            is_store = 1'($urandom);
            size     = 2'($urandom);
            addr     = $urandom;
            for (int i = 0; i < 3; i++) begin
                e = exp_vec(ml_of(i), ca_of(i), st, sz, ad[1:0], k);
                checks++;
                if (obs(i) !== e) begin
                    failures++;
                    $display("FAIL access dut%0d cyc%0d st=%0b sz=%0b addr=%h got=%b exp=%b",
                             i, k, st, sz, ad, obs(i), e);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'd0; addr = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== 13'd0) begin
                failures++;
                $display("FAIL reset dut%0d got=%b exp=0", i, obs(i));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        test_single_access(1'b0, 2'b10, 32'h0000_0010);
        test_single_access(1'b1, 2'b00, 32'h0000_0013);
        test_single_access(1'b1, 2'b10, 32'h0000_0020);
        test_single_access(1'b0, 2'b01, 32'h0000_0001);
        test_single_access(1'b0, 2'b11, 32'h0000_0004);
        test_single_access(1'b1, 2'b11, 32'h0000_0000);
        test_single_access(1'b0, 2'b01, 32'h0000_0002);
        test_single_access(1'b1, 2'b01, 32'h0000_0002);
        test_single_access(1'b1, 2'b10, 32'h0000_0022);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++)
            test_single_access(1'($urandom), 2'($urandom), $urandom);
    endtask

    // start stays high: each DUT restarts in the idle cycle after done.
    task automatic test_back_to_back();
        int          n;
        int          p;
        logic [12:0] e;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h0000_0040;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n = acc_len(ml_of(i), ca_of(i), 1'b0, 2'b10, 2'b00);
                p = ((k - 1) % (n + 1)) + 1;
                e = exp_vec(ml_of(i), ca_of(i), 1'b0, 2'b10, 2'b00, p);
                checks++;
                if (obs(i) !== e) begin
                    failures++;
                    $display("FAIL back_to_back dut%0d cyc%0d got=%b exp=%b",
                             i, k, obs(i), e);
                end
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; size = 2'b00; addr = 32'h0000_0011;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== 13'd0) begin
                    failures++;
                    $display("FAIL reset_mid dut%0d cyc%0d got=%b exp=0",
                             i, k, obs(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_single_access(1'b0, 2'b00, 32'h0000_0003);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Parametrised load/store sequencer for the multicycle datapath. Replaces the fixed single-wait LS_START/LS_WAIT/x_END path of the main control FSM. Main control hands off a start request once the effective address is in ALUOut. This block then:
- drives the memory, MDR, store-size and load-size controls;
- inserts a configurable number of memory wait cycles;
- performs read-modify-write for sub-word stores;
- flags misaligned accesses.

Parameters:
MEM_LATENCY, 1, read wait cycles between address presentation and valid read data (0..15).
CHECK_ALIGN, 1, 1 = check half/word alignment; 0 = low address bits pass through unchecked.
ADDR_W, 32, effective address width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  request from main control; sampled only in IDLE
is_store  in  1  1 = store, 0 = load; latched on accepted start
size  in  2  00 byte, 01 half, 10 word, 11 illegal; latched on accepted start
addr  in  ADDR_W  effective address (ALUOut); latched on accepted start
busy  out  1  high from cycle after accepted start through the done/align_err cycle inclusive
done  out  1  one-cycle pulse on final cycle of a successful access
align_err  out  1  one-cycle pulse on rejected access
mem_addr_sel  out  1  1 = memory address from latched addr (iord data path)
memrw  out  1  1 = memory write
mdrwrite  out  1  load MDR from memory data out
regwrite  out  1  write load result to register file
lscontrol  out  2  load extract select (=size latched)
sscontrol  out  2  store merge select (=size latched)
addr_lo  out  2  latched addr[1:0], byte-lane select for extract/merge

Behaviour:
Reset:
- All outputs 0; state IDLE; wait counter 0; latched fields 0.
- A reset mid-access abandons it. No memrw pulse is emitted after reset.

States: IDLE, ADDR, RD_WAIT, MDR_LATCH, LOAD_WB, STORE_WR, ERR.

IDLE:
- All strobes 0.
- start=1 latches is_store/size/addr.
- Next state is ERR if any of the following hold:
  - size=11;
  - CHECK_ALIGN=1 and size=01 with addr[0]=1;
  - CHECK_ALIGN=1 and size=10 with addr[1:0]≠00.
- Otherwise next state is ADDR.

ADDR:
- mem_addr_sel=1, memrw=0.
- Word store goes to STORE_WR. All other accesses go to RD_WAIT, or to MDR_LATCH if MEM_LATENCY=0.

RD_WAIT:
- mem_addr_sel=1. Counter counts up to MEM_LATENCY−1, then the state exits to MDR_LATCH.
- Counter clears on exit.

MDR_LATCH:
- mem_addr_sel=1, mdrwrite=1.
- Load goes to LOAD_WB. Sub-word store goes to STORE_WR.

LOAD_WB:
- regwrite=1, lscontrol=size, done=1. Next state IDLE.

STORE_WR:
- mem_addr_sel=1, memrw=1, sscontrol=size, done=1. Next state IDLE.

ERR:
- align_err=1. No memrw, regwrite or mdrwrite. Next state IDLE.
- Main control is responsible for raising the exception.

Timing and strobe rules:
- addr_lo and lscontrol/sscontrol are held stable from ADDR to the final cycle.
- done and align_err are mutually exclusive.
- start while busy is ignored, not queued.
- back-to-back: start may be accepted in the IDLE cycle immediately after done.

Latency, accept cycle to done, inclusive of the final cycle:
- load = 3+MEM_LATENCY;
- word store = 2;
- byte/half store = 3+MEM_LATENCY;
- error = 1.

Decomposition:
Shared package mem_access_pkg holds:
- state encoding constants;
- size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11.

One natural sub-module, wait_counter:
- clear/enable, terminal-count output at MEM_LATENCY−1;
- width $clog2(MEM_LATENCY+1), minimum 1.

The FSM and output decode stay in mem_access_ctrl.

Test Plan:
1. MEM_LATENCY=1, load word at addr=0x0000_0010.
   - Cycle sequence: ADDR, RD_WAIT×1, MDR_LATCH, LOAD_WB.
   - mdrwrite at cycle 3, regwrite+done at cycle 4, lscontrol=10, addr_lo=00, no memrw.
2. MEM_LATENCY=3, store byte at addr=0x0000_0013.
   - mdrwrite at cycle 5, then memrw=1 with sscontrol=00 and addr_lo=11 and done at cycle 6.
   - Exactly one memrw pulse.
3. Store word at 0x0000_0020 with any MEM_LATENCY.
   - memrw+done at cycle 2, no mdrwrite.
4. Misaligned accesses:
   - half load at 0x0000_0001, CHECK_ALIGN=1 → align_err at cycle 1, no memrw/regwrite/mdrwrite;
   - same with CHECK_ALIGN=0 → normal load, done at 3+MEM_LATENCY;
   - size=11 → align_err at cycle 1 in both settings.
5. Mid-access start and reset:
   - start held high throughout a load → second access accepted only in the IDLE cycle after done.
   - reset asserted in RD_WAIT → next cycle IDLE, all outputs 0, no subsequent memrw/regwrite.
6. MEM_LATENCY=0, load half at 0x0000_0002.
   - ADDR, MDR_LATCH, LOAD_WB; done at cycle 3, lscontrol=01, addr_lo=10.
